zebra_stop_fsm: RTL and testbench



---
 rtl/zebra_pkg.sv | 19 +
 rtl/frame_watchdog.sv | 37 +++
 rtl/zebra_stop_fsm.sv | 150 +++++++++++++++
 tb/tb_zebra_stop_fsm.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zebra_pkg.sv
// rtl/zebra_pkg.sv - shared state encoding and default constants for the zebra stop decision
package zebra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_STOP      = 3'd2,
    ST_RELEASING = 3'd3,
    ST_STALE     = 3'd4
  } zebra_state_e;

  localparam int DEF_CNT_W           = 19;
  localparam int DEF_WHITE_MIN       = 20000;
  localparam int DEF_ENTER_FRAMES    = 3;
  localparam int DEF_EXIT_FRAMES     = 5;
  localparam int DEF_MIN_HOLD_FRAMES = 30;
  localparam int DEF_TIMEOUT_CYCLES  = 840000;

endpackage

// File: rtl/frame_watchdog.sv
// rtl/frame_watchdog.sv - saturating cycles-since-last-frame counter with a one-shot timeout pulse
module frame_watchdog #(
  parameter int TIMEOUT_CYCLES = 840000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES);

  logic [W-1:0] r_cnt;
  logic         r_fired;
  logic         w_term;

  assign w_term = (r_cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_fired <= 1'b0;
    end else if (!enable || clear) begin
      r_cnt   <= '0;
      r_fired <= 1'b0;
    end else begin
      if (!w_term) r_cnt <= r_cnt + W'(1);
      if (w_term)  r_fired <= 1'b1;
    end
  end

  // Fires once per silent period; a frame arriving on the terminal cycle suppresses it.
  assign timeout = enable & ~clear & ~r_fired & w_term;

endmodule

// File: rtl/zebra_stop_fsm.sv
// rtl/zebra_stop_fsm.sv - hysteresis/min-hold debounce of per-frame crossing verdicts into a stop request
module zebra_stop_fsm
  import zebra_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int WHITE_MIN       = DEF_WHITE_MIN,
  parameter int ENTER_FRAMES    = DEF_ENTER_FRAMES,
  parameter int EXIT_FRAMES     = DEF_EXIT_FRAMES,
  parameter int MIN_HOLD_FRAMES = DEF_MIN_HOLD_FRAMES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             detection_valid,
  input  logic             crossing_detected,
  input  logic [CNT_W-1:0] white_count,
  output logic             stop,
  output logic             stale,
  output logic [2:0]       state_o,
  output logic [7:0]       frame_count
);

  localparam int HIT_W  = $clog2(ENTER_FRAMES + 1);
  localparam int MISS_W = $clog2(EXIT_FRAMES + 1);
  localparam int HOLD_W = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0]  WHITE_MIN_C = CNT_W'(WHITE_MIN);
  localparam logic [HIT_W-1:0]  ENTER_LAST  = HIT_W'(ENTER_FRAMES - 1);
  localparam logic [MISS_W-1:0] EXIT_LAST   = MISS_W'(EXIT_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(MIN_HOLD_FRAMES);

  zebra_state_e       r_state;
  logic [HIT_W-1:0]   r_hit;
  logic [HOLD_W-1:0]  r_hold;
  logic [MISS_W-1:0]  r_miss;
  logic [7:0]         r_frame_count;
  logic               r_stop;
  logic               r_stale;
  logic               w_pos;
  logic               w_timeout;

  assign w_pos = detection_valid & crossing_detected & (white_count >= WHITE_MIN_C);

  frame_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .clear   (detection_valid),
    .timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_hit         <= '0;
      r_hold        <= '0;
      r_miss        <= '0;
      r_frame_count <= '0;
      r_stop        <= 1'b0;
      r_stale       <= 1'b0;
    end else if (!enable) begin
      r_state       <= ST_IDLE;
      r_hit         <= '0;
      r_hold        <= '0;
      r_miss        <= '0;
      r_frame_count <= '0;
      r_stop        <= 1'b0;
      r_stale       <= 1'b0;
    end else if (detection_valid) begin
      r_frame_count <= r_frame_count + 8'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_pos) begin
            if (ENTER_FRAMES == 1) begin
              r_state <= ST_STOP;
              r_stop  <= 1'b1;
              r_hold  <= '0;
            end else begin
              r_state <= ST_ARMING;
              r_hit   <= HIT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          if (!w_pos) begin
            r_state <= ST_IDLE;
            r_hit   <= '0;
          end else if (r_hit == ENTER_LAST) begin
            r_state <= ST_STOP;
            r_stop  <= 1'b1;
            r_hit   <= '0;
            r_hold  <= '0;
          end else begin
            r_hit <= r_hit + HIT_W'(1);
          end
        end
        ST_STOP: begin
          // Every frame ages the hold; only a negative frame after the hold starts the release.
          if (w_pos || r_hold != HOLD_MAX) begin
            if (r_hold != HOLD_MAX) r_hold <= r_hold + HOLD_W'(1);
          end else if (EXIT_FRAMES == 1) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b0;
            r_hold  <= '0;
          end else begin
            r_state <= ST_RELEASING;
            r_miss  <= MISS_W'(1);
          end
        end
        ST_RELEASING: begin
          if (w_pos) begin
            r_state <= ST_STOP;
            r_miss  <= '0;
          end else if (r_miss == EXIT_LAST) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b0;
            r_miss  <= '0;
            r_hold  <= '0;
          end else begin
            r_miss <= r_miss + MISS_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stop  <= 1'b0;
          r_stale <= 1'b0;
          r_hit   <= '0;
          r_hold  <= '0;
          r_miss  <= '0;
        end
      endcase
    end else if (w_timeout) begin
      r_state <= ST_STALE;
      r_stop  <= 1'b1;
      r_stale <= 1'b1;
      r_hit   <= '0;
      r_hold  <= '0;
      r_miss  <= '0;
    end
  end

  assign stop        = r_stop;
  assign stale       = r_stale;
  assign state_o     = r_state;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_zebra_stop_fsm.sv
// tb/tb_zebra_stop_fsm.sv - scenario and randomized checks of zebra_stop_fsm against a frame-level model
module tb_zebra_stop_fsm;

  localparam int CNT_W = 19;
  localparam int WMIN  = 100;
  localparam int ENTER = 3;
  localparam int EXIT  = 5;
  localparam int HOLD  = 4;
  localparam int TMO   = 1000;
  localparam int GAP   = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             detection_valid = 1'b0;
  logic             crossing_detected = 1'b0;
  logic [CNT_W-1:0] white_count = '0;
  logic             stop;
  logic             stale;
  logic [2:0]       state_o;
  logic [7:0]       frame_count;

  int total = 0;
  int bad = 0;
  int m_state, m_hit, m_hold, m_miss, m_frames, m_idle;

  always #5 clk = ~clk;

  zebra_stop_fsm #(
    .CNT_W(CNT_W), .WHITE_MIN(WMIN), .ENTER_FRAMES(ENTER), .EXIT_FRAMES(EXIT),
    .MIN_HOLD_FRAMES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .detection_valid(detection_valid),
    .crossing_detected(crossing_detected), .white_count(white_count),
    .stop(stop), .stale(stale), .state_o(state_o), .frame_count(frame_count)
  );

  task automatic m_clear();
    m_state = 0; m_hit = 0; m_hold = 0; m_miss = 0; m_frames = 0; m_idle = 0;
  endtask

  // Frame-rule model: one call per clock edge, with the inputs that edge sampled.
  task automatic m_step(bit dv, bit cd, int wc);
    bit pos;
    pos = dv && cd && (wc >= WMIN);
    if (!enable) begin
      m_clear();
      return;
    end
    if (!dv) begin
      if (m_idle == TMO) begin
        m_state = 4; m_hit = 0; m_hold = 0; m_miss = 0;
      end
      if (m_idle < TMO) m_idle++;
      return;
    end
    m_idle = 0;
    m_frames = (m_frames + 1) % 256;
    case (m_state)
      0: if (pos) begin m_state = 1; m_hit = 1; end
      1: if (pos) begin
           m_hit++;
           if (m_hit == ENTER) begin m_state = 2; m_hold = 0; end
         end else begin m_state = 0; m_hit = 0; end
      2: if (pos) m_hold = (m_hold < HOLD) ? m_hold + 1 : HOLD;
         else if (m_hold >= HOLD) begin m_state = 3; m_miss = 1; end
         else m_hold++;
      3: if (pos) begin m_state = 2; m_miss = 0; end
         else begin
           m_miss++;
           if (m_miss == EXIT) m_state = 0;
         end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [12:0] m_expect();
    return {m_state >= 2 && m_state <= 4, m_state == 4, 3'(m_state), 8'(m_frames)};
  endfunction

  task automatic cycle(bit dv, bit cd, int wc);
    detection_valid = dv;
    crossing_detected = cd;
    white_count = CNT_W'(wc);
    @(negedge clk);
    m_step(dv, cd, wc);
    detection_valid = 1'b0;
  endtask

  task automatic frame(bit cd, int wc);
    repeat (GAP - 1) cycle(1'b0, 1'b0, 0);
    cycle(1'b1, cd, wc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    m_clear();
    repeat (3) @(negedge clk);
    total++;
    if ({stop, stale, state_o, frame_count} !== 13'd0) begin
      bad++;
      $display("FAIL reset: got %h want 0", {stop, stale, state_o, frame_count});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_entry();
    int  exp_st[6] = '{1, 1, 0, 1, 1, 2};
    bit  pat[6]    = '{1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      frame(pat[i], 500);
      total++;
      if (state_o !== 3'(exp_st[i])) begin
        bad++;
        $display("FAIL entry state #%0d: got %0d want %0d", i, state_o, exp_st[i]);
      end
      total++;
      if ({stop, stale, state_o, frame_count} !== m_expect()) begin
        bad++;
        $display("FAIL entry model #%0d: got %h want %h", i, {stop, stale, state_o, frame_count}, m_expect());
      end
    end
    total++;
    if (stop !== 1'b1) begin bad++; $display("FAIL entry stop: got %b want 1", stop); end
  endtask

  task automatic test_hold_exit();
    int exp_st[9] = '{2, 2, 2, 2, 3, 3, 3, 3, 0};
    for (int i = 0; i < 9; i++) begin
      frame(1'b0, 500);
      total++;
      if (state_o !== 3'(exp_st[i]) || stop !== (exp_st[i] != 0)) begin
        bad++;
        $display("FAIL hold_exit #%0d: got state %0d stop %b want state %0d", i, state_o, stop, exp_st[i]);
      end
    end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 10; i++) begin
      frame(1'b1, 99);
      total++;
      if ({stop, state_o} !== 4'd0) begin
        bad++;
        $display("FAIL threshold below #%0d: got stop %b state %0d want 0 0", i, stop, state_o);
      end
    end
    repeat (3) frame(1'b1, 100);
    total++;
    if ({stop, stale, state_o, frame_count} !== m_expect() || stop !== 1'b1) begin
      bad++;
      $display("FAIL threshold at min: got %h want %h", {stop, stale, state_o, frame_count}, m_expect());
    end
  endtask

  task automatic test_release_abort();
    int exp_st[4] = '{3, 3, 3, 0};
    repeat (4) frame(1'b1, 500);
    repeat (3) frame(1'b0, 500);
    total++;
    if (state_o !== 3'd3) begin bad++; $display("FAIL abort pre: got %0d want 3", state_o); end
    frame(1'b1, 500);
    total++;
    if (state_o !== 3'd2 || stop !== 1'b1) begin
      bad++;
      $display("FAIL abort pos: got state %0d stop %b want 2 1", state_o, stop);
    end
    frame(1'b0, 500);
    total++;
    if (state_o !== 3'd3) begin bad++; $display("FAIL abort reenter: got %0d want 3", state_o); end
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 500);
      total++;
      if (state_o !== 3'(exp_st[i])) begin
        bad++;
        $display("FAIL abort miss #%0d: got %0d want %0d", i, state_o, exp_st[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] exp_fc;
    repeat (TMO) cycle(1'b0, 1'b0, 0);
    total++;
    if ({stop, stale} !== 2'b00) begin bad++; $display("FAIL wd early: got %b%b want 00", stop, stale); end
    cycle(1'b0, 1'b0, 0);
    total++;
    if ({stop, stale, state_o} !== 5'b11_100) begin
      bad++;
      $display("FAIL wd fire: got %b want 11100", {stop, stale, state_o});
    end
    exp_fc = 8'((m_frames + 1) % 256);
    frame(1'b1, 500);
    total++;
    if ({stop, stale, state_o} !== 5'd0 || frame_count !== exp_fc) begin
      bad++;
      $display("FAIL wd recover: got %b fc %0d want 00000 fc %0d", {stop, stale, state_o}, frame_count, exp_fc);
    end
    repeat (TMO) cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    total++;
    if (stale !== 1'b0 || {stop, stale, state_o, frame_count} !== m_expect()) begin
      bad++;
      $display("FAIL wd tie: got %h want %h", {stop, stale, state_o, frame_count}, m_expect());
    end
  endtask

  task automatic test_reset_enable();
    repeat (7) frame(1'b1, 500);
    frame(1'b0, 500);
    total++;
    if (state_o !== 3'd3) begin bad++; $display("FAIL rst pre: got %0d want 3", state_o); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({stop, stale, state_o, frame_count} !== 13'd0) begin
      bad++;
      $display("FAIL async reset: got %h want 0", {stop, stale, state_o, frame_count});
    end
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame(1'b1, 500);
    total++;
    if (state_o !== 3'd2) begin bad++; $display("FAIL en pre: got %0d want 2", state_o); end
    enable = 1'b0;
    cycle(1'b1, 1'b1, 500);
    total++;
    if ({stop, stale, state_o, frame_count} !== 13'd0) begin
      bad++;
      $display("FAIL enable low: got %h want 0", {stop, stale, state_o, frame_count});
    end
    enable = 1'b1;
    for (int i = 0; i < 260; i++) frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 300)));
    total++;
    if (frame_count !== 8'd4 || {stop, stale, state_o, frame_count} !== m_expect()) begin
      bad++;
      $display("FAIL frame wrap: got fc %0d bundle %h want fc 4 bundle %h", frame_count,
               {stop, stale, state_o, frame_count}, m_expect());
    end
  endtask

  task automatic test_back_to_back();
    int exp_st[3] = '{1, 1, 2};
    repeat (10) cycle(1'b1, 1'b0, 0);
    total++;
    if (state_o !== 3'd0) begin bad++; $display("FAIL b2b idle: got %0d want 0", state_o); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 500);
      total++;
      if (state_o !== 3'(exp_st[i]) || {stop, stale, state_o, frame_count} !== m_expect()) begin
        bad++;
        $display("FAIL b2b #%0d: got state %0d want %0d", i, state_o, exp_st[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 299) != 0);
      if (i == 1500) repeat (TMO + 3) cycle(1'b0, 1'b0, 0);
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(95, 105)));
      total++;
      if ({stop, stale, state_o, frame_count} !== m_expect()) begin
        bad++;
        $display("FAIL random cyc %0d: got %h want %h", i, {stop, stale, state_o, frame_count}, m_expect());
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_entry();
    test_hold_exit();
    test_threshold();
    test_release_abort();
    test_watchdog();
    test_reset_enable();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
